inst_stage_fifo: RTL and testbench

Host-side staging buffer that sits directly upstream of the IRAM instruction loader FSM. Software pushes (IRAM address, instruction) pairs into a small FIFO. On a go command the block drains the FIFO one entry at a time into the loader, using a single-cycle request and the loader's done flag. It reports progress, completion and errors back to the register interface.

---
 rtl/inst_stage_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_inst_stage_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_stage_fifo.sv
// inst_stage_fifo: host-side staging FIFO in front of the IRAM loader.
// Software pushes {address, instruction} pairs. A go pulse drains them one at
// a time into the loader with a one-cycle load_req, waiting on the rising edge
// of load_done. Progress, completion and sticky errors go back to the host.
module inst_stage_fifo #(
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_inst,
    input  logic              go,
    output logic [PTR_W:0]    fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] inst_out,
    output logic              load_req,
    input  logic              load_done,
    output logic              busy,
    output logic              drain_done,
    output logic              err_overflow,
    output logic              err_timeout
);

    localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        POP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_inst [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_nxt;
    logic [TMR_W-1:0]  timer;
    logic              load_done_q;
    logic              done_rise;
    logic              push;
    logic              pop;

    logic              latch_head;
    logic              latch_next;
    logic              drain_fin;
    logic              timeout_hit;

    // A push during clear is discarded; a push while full is dropped.
    assign push       = host_wr_en && !fifo_full && !clear;
    assign pop        = (state == POP);
    assign done_rise  = load_done & ~load_done_q;
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    assign count_nxt  = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    assign fifo_count = count;
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE);

    // Next-state and per-state strobes for the drain sequencer.
    always_comb begin
        state_nxt   = state;
        latch_head  = 1'b0;
        latch_next  = 1'b0;
        drain_fin   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (!fifo_empty) begin
                        latch_head = 1'b1;
                        state_nxt  = ISSUE;
                    end else begin
                        drain_fin  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    state_nxt = POP;
                end else if (timer == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            POP: begin
                if (count_nxt == '0) begin
                    drain_fin = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    latch_next = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, pointers, occupancy, timer, strobes and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            timer        <= '0;
            load_done_q  <= 1'b0;
            load_req     <= 1'b0;
            drain_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            load_done_q <= load_done;
            if (clear) begin
                state        <= IDLE;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
                timer        <= '0;
                load_req     <= 1'b0;
                drain_done   <= 1'b0;
                err_overflow <= 1'b0;
                err_timeout  <= 1'b0;
            end else begin
                state      <= state_nxt;
                count      <= count_nxt;
                load_req   <= (state_nxt == ISSUE);
                drain_done <= drain_fin;
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr_inc;
                end
                if (state == ISSUE) begin
                    timer <= '0;
                end else if (state == WAIT) begin
                    timer <= timer + TMR_W'(1);
                end
                if (host_wr_en && fifo_full) begin
                    err_overflow <= 1'b1;
                end
                if (timeout_hit) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= host_addr;
            mem_inst[wr_ptr] <= host_inst;
        end
    end

    // Loader-facing entry: latched on go and after each pop, held otherwise.
    // When the last stored entry is popped while a new one is pushed, the new
    // head is not in storage yet, so it is taken straight from the host bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out <= '0;
            inst_out <= '0;
        end else if (!clear) begin
            if (latch_head) begin
                addr_out <= mem_addr[rd_ptr];
                inst_out <= mem_inst[rd_ptr];
            end else if (latch_next) begin
                if (count == CNT_ONE) begin
                    addr_out <= host_addr;
                    inst_out <= host_inst;
                end else begin
                    addr_out <= mem_addr[rd_ptr_inc];
                    inst_out <= mem_inst[rd_ptr_inc];
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_stage_fifo.sv
// Directed testbench for inst_stage_fifo: a queue of expected entries plus a
// scripted loader that answers each load_req a fixed number of cycles later.
module tb_inst_stage_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        host_wr_en;
    logic [8:0]  host_addr;
    logic [31:0] host_inst;
    logic        go;
    logic [4:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  addr_out;
    logic [31:0] inst_out;
    logic        load_req;
    logic        load_done;
    logic        busy;
    logic        drain_done;
    logic        err_overflow;
    logic        err_timeout;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [40:0] exp_q[$];
    int          model_cnt   = 0;

    inst_stage_fifo #(
        .DEPTH(16), .PTR_W(4), .ADDR_W(9), .DATA_W(32), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .host_wr_en(host_wr_en), .host_addr(host_addr), .host_inst(host_inst),
        .go(go), .fifo_count(fifo_count), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .addr_out(addr_out), .inst_out(inst_out),
        .load_req(load_req), .load_done(load_done), .busy(busy),
        .drain_done(drain_done), .err_overflow(err_overflow),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push while no drain is running; the model accepts at most 16 entries.
    task automatic push_entry(input logic [8:0] a, input logic [31:0] i);
        host_wr_en = 1'b1;
        host_addr  = a;
        host_inst  = i;
        tick();
        host_wr_en = 1'b0;
        if (model_cnt < 16) begin
            exp_q.push_back({a, i});
            model_cnt++;
        end
    endtask

    // Wait for load_req, check the presented entry, answer after 'delay' cycles,
    // optionally pushing a new entry in the POP cycle.
    task automatic serve(input int delay, input bit do_push,
                         input logic [8:0] pa, input logic [31:0] pi);
        int          n;
        logic [40:0] e;
        n = 0;
        while (load_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("load_req_seen", load_req, 1);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("addr_out", addr_out, e[40:32]);
        check("inst_out", inst_out, e[31:0]);
        repeat (delay - 1) tick();
        check("addr_hold", addr_out, e[40:32]);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        model_cnt--;
        if (do_push) begin
            host_wr_en = 1'b1;
            host_addr  = pa;
            host_inst  = pi;
            exp_q.push_back({pa, pi});
            model_cnt++;
            tick();
            host_wr_en = 1'b0;
            check("push_pop_count", fifo_count, model_cnt);
        end
    endtask

    task automatic drain_end();
        tick();
        check("drain_done_hi", drain_done, 1);
        check("drain_count", fifo_count, 0);
        check("drain_busy", busy, 0);
        check("drain_no_req", load_req, 0);
        tick();
        check("drain_done_lo", drain_done, 0);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; host_wr_en = 1'b0; host_addr = '0;
        host_inst = '0; go = 1'b0; load_done = 1'b0;
        tick();
        tick();
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_busy", busy, 0);
        check("rst_req", load_req, 0);
        check("rst_addr", addr_out, 0);
        rst_n = 1'b1;
        tick();

        // Basic two-entry drain
        push_entry(9'h000, 32'hDEADBEEF);
        push_entry(9'h001, 32'h12345678);
        check("basic_count", fifo_count, 2);
        check("basic_empty", fifo_empty, 0);
        pulse_go();
        check("go_latency_req", load_req, 1);
        check("go_busy", busy, 1);
        serve(4, 1'b0, '0, '0);
        serve(4, 1'b0, '0, '0);
        drain_end();

        // go with an empty FIFO
        pulse_go();
        check("empty_go_done", drain_done, 1);
        check("empty_go_req", load_req, 0);
        check("empty_go_busy", busy, 0);
        tick();
        check("empty_go_done_lo", drain_done, 0);

        // Timeout on an unresponsive loader, then retry
        push_entry(9'h0AB, 32'hCAFEF00D);
        pulse_go();
        check("to_req", load_req, 1);
        repeat (64) tick();
        check("to_busy_last_wait", busy, 1);
        check("to_err_before", err_timeout, 0);
        tick();
        check("to_err", err_timeout, 1);
        check("to_idle", busy, 0);
        check("to_count", fifo_count, 1);
        pulse_go();
        serve(4, 1'b0, '0, '0);
        drain_end();
        check("to_err_sticky", err_timeout, 1);

        // Push during the final pop: new head bypasses storage
        push_entry(9'h100, 32'h11111111);
        pulse_go();
        serve(3, 1'b1, 9'h101, 32'h22222222);
        serve(3, 1'b0, '0, '0);
        drain_end();

        // Overflow: 17 pushes, only the first 16 kept
        for (int k = 0; k < 17; k++) push_entry(9'(9'h020 + k), 32'hA0000000 + k);
        check("ovf_count", fifo_count, 16);
        check("ovf_full", fifo_full, 1);
        check("ovf_err", err_overflow, 1);
        pulse_go();
        for (int k = 0; k < 16; k++) serve(2, 1'b0, '0, '0);
        drain_end();
        check("ovf_err_sticky", err_overflow, 1);

        // Clear during WAIT with 5 queued, plus a push on the clear cycle
        for (int k = 0; k < 5; k++) push_entry(9'(9'h040 + k), 32'hD0000000 + k);
        pulse_go();
        tick();
        check("clr_busy_before", busy, 1);
        clear = 1'b1;
        host_wr_en = 1'b1; host_addr = 9'h1FF; host_inst = 32'hFFFFFFFF;
        tick();
        clear = 1'b0;
        host_wr_en = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        check("clr_count", fifo_count, 0);
        check("clr_empty", fifo_empty, 1);
        check("clr_busy", busy, 0);
        check("clr_err_ovf", err_overflow, 0);
        check("clr_err_to", err_timeout, 0);
        check("clr_req", load_req, 0);
        check("clr_addr_held", addr_out, 9'h040);
        check("clr_inst_held", inst_out, 32'hD0000000);

        // Wrap: 12 queued, 8 more pushed in POP cycles during the drain
        for (int k = 0; k < 12; k++) push_entry(9'(9'h080 + k), 32'hB0000000 + k);
        pulse_go();
        for (int k = 0; k < 20; k++)
            serve(2, (k < 8), 9'(9'h180 + k), 32'hC0000000 + k);
        drain_end();

        // Asynchronous reset in the middle of WAIT
        push_entry(9'h055, 32'h55555555);
        push_entry(9'h056, 32'h66666666);
        pulse_go();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_count", fifo_count, 0);
        check("arst_empty", fifo_empty, 1);
        check("arst_req", load_req, 0);
        check("arst_addr", addr_out, 0);
        check("arst_inst", inst_out, 0);
        check("arst_errs", {err_overflow, err_timeout, drain_done}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
